seq_pattern_match_ctrl: RTL and testbench
=========================================

// Module: seq_pattern_match_ctrl
//
// PURPOSE
// - Programmable serial pattern-match controller. Generalises the fixed
//   "1110" detector FSM into a configurable engine.
// - Software loads a pattern and its length; the block then consumes a
//   valid/ready bit stream and pulses out on every (overlapping) match.
// - Keeps a saturating match counter and an optional sticky interrupt.
//
// PARAMETERS
// - PAT_W  default 4  max pattern length in bits (>=2)
// - CNT_W  default 8  match counter width
// - LEN_W  derived    $clog2(PAT_W)+1; not overridden
//
// PORTS
// - clk          in   1      clock
// - reset        in   1      synchronous, active-high reset
// - cfg_en       in   1      load cfg_pattern/cfg_len this cycle
// - cfg_pattern  in   PAT_W  pattern; bit [cfg_len-1] = first bit in time
// - cfg_len      in   LEN_W  pattern length, legal range 1..PAT_W
// - cfg_err      out  1      1-cycle pulse: illegal cfg_len was rejected
// - in_val       in   1      stream bit valid
// - in_          in   1      stream bit
// - in_rdy       out  1      (state==ARMED) && !cfg_en (combinational)
// - out          out  1      registered match pulse
// - match_count  out  CNT_W  matches since last config, saturating
// - armed        out  1      state==ARMED
// - irq          out  1      sticky match interrupt (see CONFIGURATION)
// - irq_clr      in   1      clears irq
//
// BEHAVIOUR
// - Reset: state=IDLE; pattern, len, hist, fill, match_count, out, cfg_err
//   and irq all 0; in_rdy=0.
// - FSM:
//   IDLE  -> ARMED on cfg_en with 1<=cfg_len<=PAT_W.
//   ARMED -> ARMED on any cfg_en with a legal length (reload).
//   Any state -> IDLE on cfg_en with an illegal length (0 or >PAT_W);
//   cfg_err pulses in the next cycle.
// - A legal load latches the pattern and length and clears hist, fill,
//   match_count and out. irq is not cleared by a load.
// - Accept occurs when in_val && in_rdy at the clock edge:
//   hist <= {hist[PAT_W-2:0], in_}; fill <= min(fill+1, PAT_W).
// - Match condition on an accepting edge: fill_next >= len and
//   hist_next[len-1:0] == pattern[len-1:0]. Matches overlap (sliding
//   window). Example: 1110 with input 1,1,1,1,0 matches once.
// - On a match, out is 1 for exactly one cycle after the edge (Moore-style
//   latency 1). match_count increments on the same edge and holds at
//   2^CNT_W-1.
// - Cycles with no accept: hist and fill hold; out=0.
// - cfg_en together with in_val: the config wins and the bit is not
//   accepted (in_rdy=0).
// - Reset mid-stream: everything returns to the reset values on the next
//   edge, including partial-match history.
//
// CONFIGURATION
// - SEQ_PATTERN_MATCH_CTRL_IRQ_EN defined:
//   - irq sets on any match edge and stays 1 until irq_clr.
//   - If irq_clr and a match occur on the same edge, set wins.
//   - irq is cleared by reset.
// - Macro not defined: irq is tied to 0 and irq_clr is ignored.
//
// TESTING
// - Reset then cfg pattern=4'b1110, len=4; stream 0,1,0,1,1,0,1,1,1,1,0,0
//   -> out pulses once, 1 cycle after the final 0 of 1,1,1,1,0;
//   match_count=1.
// - len=2, pattern=2'b11; stream 1,1,1,1 -> out high 3 consecutive cycles
//   (overlap); match_count=3.
// - Gaps: in_val toggles 0/1 across the 1,1,1,0 sequence -> single match;
//   idle cycles never advance hist or produce out.
// - cfg_len=0, then cfg_len=PAT_W+1 -> cfg_err pulses each time; state
//   IDLE; in_rdy=0; no matches.
// - CNT_W=2: 5 matches -> match_count saturates at 3. Reload clears it
//   to 0.
// - Reset asserted after bits 1,1,1, then reload and send 0 -> no match.
//   With IRQ_EN: irq stays set until irq_clr; same-edge match+clr -> irq=1.

Source files
------------

// File: rtl/seq_pattern_match_ctrl.sv
// Programmable serial pattern matcher with overlap and saturating count.
// Optional sticky irq: define SEQ_PATTERN_MATCH_CTRL_IRQ_EN.
module seq_pattern_match_ctrl #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  localparam int LEN_W = $clog2(PAT_W) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_en,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  output logic             cfg_err,
  input  logic             in_val,
  input  logic             in_,
  output logic             in_rdy,
  output logic             out,
  output logic [CNT_W-1:0] match_count,
  output logic             armed,
  output logic             irq,
  input  logic             irq_clr
);

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_e;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PAT_W);

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             err_q, err_d;
  logic [PAT_W-1:0] mask;
  logic             len_ok;
  logic             accept;
  logic             match;

  assign len_ok      = (cfg_len != '0) && (cfg_len <= MAX_LEN);
  assign in_rdy      = (state_q == ARMED) && !cfg_en;
  assign accept      = in_val && in_rdy;
  assign armed       = (state_q == ARMED);
  assign out         = out_q;
  assign cfg_err     = err_q;
  assign match_count = cnt_q;

  // Compare mask: only the low len bits of the window take part.
  always_comb begin
    mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (LEN_W'(i) < len_q);
    end
  end

  // Config load, bit accept, window compare and counter update.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    out_d   = 1'b0;
    err_d   = 1'b0;
    match   = 1'b0;
    if (cfg_en) begin
      if (len_ok) begin
        state_d = ARMED;
        pat_d   = cfg_pattern;
        len_d   = cfg_len;
        hist_d  = '0;
        fill_d  = '0;
        cnt_d   = '0;
      end else begin
        state_d = IDLE;
        err_d   = 1'b1;
      end
    end else if (accept) begin
      hist_d = {hist_q[PAT_W-2:0], in_};
      fill_d = (fill_q == MAX_LEN) ? fill_q : fill_q + 1'b1;
      match  = (fill_d >= len_q) &&
               (((hist_d ^ pat_q) & mask) == '0);
      out_d  = match;
      if (match && (cnt_q != '1)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      hist_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

`ifdef SEQ_PATTERN_MATCH_CTRL_IRQ_EN
  logic irq_q, irq_d;

  // Sticky interrupt; a match on the clearing edge keeps it set.
  always_comb begin
    irq_d = irq_q;
    if (irq_clr) irq_d = 1'b0;
    if (match)   irq_d = 1'b1;
  end

  // Interrupt register.
  always_ff @(posedge clk) begin
    if (reset) irq_q <= 1'b0;
    else       irq_q <= irq_d;
  end

  assign irq = irq_q;
`else
  logic unused_irq_clr;
  assign unused_irq_clr = irq_clr;
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_seq_pattern_match_ctrl.sv
// Bench for seq_pattern_match_ctrl: vector table, corner sequences,
// and random stream checked against a bit-queue reference model.
module tb_seq_pattern_match_ctrl;

  localparam int PAT_W = 4;
  localparam int CNT_W = 8;
  localparam int LEN_W = $clog2(PAT_W) + 1;
  localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef SEQ_PATTERN_MATCH_CTRL_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             cfg_en = 1'b0;
  logic [PAT_W-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic             cfg_err;
  logic             in_val = 1'b0;
  logic             in_ = 1'b0;
  logic             in_rdy;
  logic             out;
  logic [CNT_W-1:0] match_count;
  logic             armed;
  logic             irq;
  logic             irq_clr = 1'b0;

  seq_pattern_match_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .cfg_en(cfg_en),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_err(cfg_err),
    .in_val(in_val), .in_(in_), .in_rdy(in_rdy), .out(out),
    .match_count(match_count), .armed(armed), .irq(irq),
    .irq_clr(irq_clr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // reference model state
  bit       m_known = 0;
  bit       m_armed = 0;
  bit [3:0] m_pat = 0;
  int       m_len = 0;
  bit       m_q[$];
  int       m_cnt = 0;
  bit       m_out = 0;
  bit       m_err = 0;
  bit       m_irq = 0;
  bit       last_rdy;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_edge(input bit rst, input bit cfg,
                            input bit [3:0] pat, input int len,
                            input bit val, input bit b, input bit clr);
    bit rdy;
    bit hit;
    hit = 0;
    if (rst) begin
      m_armed = 0; m_pat = 0; m_len = 0; m_q.delete();
      m_cnt = 0; m_out = 0; m_err = 0; m_irq = 0; m_known = 1;
      return;
    end
    rdy = m_armed && !cfg;
    m_out = 0;
    m_err = 0;
    if (cfg) begin
      if (len >= 1 && len <= PAT_W) begin
        m_armed = 1; m_pat = pat; m_len = len;
        m_q.delete(); m_cnt = 0;
      end else begin
        m_armed = 0; m_err = 1;
      end
    end else if (val && rdy) begin
      m_q.push_back(b);
      if (m_q.size() > PAT_W) void'(m_q.pop_front());
      if (m_q.size() >= m_len) begin
        hit = 1;
        for (int k = 0; k < m_len; k++)
          if (m_q[m_q.size() - 1 - k] != m_pat[k]) hit = 0;
      end
      if (hit) begin
        m_out = 1;
        if (m_cnt < CMAX) m_cnt++;
      end
    end
    if (IRQ_ON) begin
      if (clr) m_irq = 0;
      if (hit) m_irq = 1;
    end
  endtask

  task automatic step(input bit rst, input bit cfg, input bit [3:0] pat,
                      input int len, input bit val, input bit b,
                      input bit clr);
    @(negedge clk);
    reset = rst; cfg_en = cfg; cfg_pattern = pat;
    cfg_len = LEN_W'(len); in_val = val; in_ = b; irq_clr = clr;
    #1;
    last_rdy = in_rdy;
    if (m_known) chk("in_rdy", int'(in_rdy), int'(m_armed && !cfg));
    @(posedge clk);
    model_edge(rst, cfg, pat, len, val, b, clr);
    #1;
    chk("out", int'(out), int'(m_out));
    chk("match_count", int'(match_count), m_cnt);
    chk("cfg_err", int'(cfg_err), int'(m_err));
    chk("armed", int'(armed), int'(m_armed));
    chk("irq", int'(irq), int'(m_irq));
  endtask

  typedef struct {
    bit rst; bit cfg; bit [3:0] pat; int len; bit val; bit b;
    bit rdy; bit out; int cnt; bit err; bit arm;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(bit rst, bit cfg, bit [3:0] pat, int len,
                             bit val, bit b, bit rdy, bit o, int cnt,
                             bit err, bit arm);
    vec_t r;
    r.rst = rst; r.cfg = cfg; r.pat = pat; r.len = len;
    r.val = val; r.b = b; r.rdy = rdy; r.out = o; r.cnt = cnt;
    r.err = err; r.arm = arm;
    return r;
  endfunction

  initial begin
    int sb[12];
    sb = '{0, 1, 0, 1, 1, 0, 1, 1, 1, 1, 0, 0};
    // 1110 detect across a noisy stream
    tbl.push_back(v(1, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 4'he, 4, 0, 0, 0, 0, 0, 0, 1));
    for (int k = 0; k < 12; k++)
      tbl.push_back(v(0, 0, 4'h0, 0, 1, sb[k][0], 1,
                      k == 10, (k >= 10) ? 1 : 0, 0, 1));
    // overlapping 11; config beats a valid bit
    tbl.push_back(v(0, 1, 4'h3, 2, 1, 1, 0, 0, 0, 0, 1));
    for (int k = 0; k < 4; k++)
      tbl.push_back(v(0, 0, 4'h0, 0, 1, 1, 1, k > 0, k, 0, 1));
    // illegal lengths
    tbl.push_back(v(0, 1, 4'h3, 0, 1, 1, 0, 0, 3, 1, 0));
    tbl.push_back(v(0, 0, 4'h0, 0, 1, 1, 0, 0, 3, 0, 0));
    tbl.push_back(v(0, 1, 4'hf, 5, 0, 0, 0, 0, 3, 1, 0));
    tbl.push_back(v(0, 0, 4'h0, 0, 1, 1, 0, 0, 3, 0, 0));
    // gaps in in_val around 1,1,1,0
    tbl.push_back(v(0, 1, 4'he, 4, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(v(0, 0, 4'h0, 0, 1, 1, 1, 0, 0, 0, 1));
    tbl.push_back(v(0, 0, 4'h0, 0, 0, 0, 1, 0, 0, 0, 1));
    tbl.push_back(v(0, 0, 4'h0, 0, 1, 1, 1, 0, 0, 0, 1));
    tbl.push_back(v(0, 0, 4'h0, 0, 0, 0, 1, 0, 0, 0, 1));
    tbl.push_back(v(0, 0, 4'h0, 0, 1, 1, 1, 0, 0, 0, 1));
    tbl.push_back(v(0, 0, 4'h0, 0, 0, 1, 1, 0, 0, 0, 1));
    tbl.push_back(v(0, 0, 4'h0, 0, 1, 0, 1, 1, 1, 0, 1));
    tbl.push_back(v(0, 0, 4'h0, 0, 0, 0, 1, 0, 1, 0, 1));
    // reset mid-stream drops partial history
    tbl.push_back(v(0, 1, 4'he, 4, 0, 0, 0, 0, 0, 0, 1));
    for (int k = 0; k < 3; k++)
      tbl.push_back(v(0, 0, 4'h0, 0, 1, 1, 1, 0, 0, 0, 1));
    tbl.push_back(v(1, 0, 4'h0, 0, 1, 1, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 4'he, 4, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(v(0, 0, 4'h0, 0, 1, 0, 1, 0, 0, 0, 1));

    step(1, 0, 0, 0, 0, 0, 0);
    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].cfg, tbl[i].pat, tbl[i].len,
           tbl[i].val, tbl[i].b, 0);
      chk($sformatf("tbl%0d_rdy", i), int'(last_rdy), int'(tbl[i].rdy));
      chk($sformatf("tbl%0d_out", i), int'(out), int'(tbl[i].out));
      chk($sformatf("tbl%0d_cnt", i), int'(match_count), tbl[i].cnt);
      chk($sformatf("tbl%0d_err", i), int'(cfg_err), int'(tbl[i].err));
      chk($sformatf("tbl%0d_arm", i), int'(armed), int'(tbl[i].arm));
    end

    // counter saturation, then reload clears it
    step(0, 1, 4'h1, 1, 0, 0, 0);
    repeat (CMAX + 45) step(0, 0, 0, 0, 1, 1, 0);
    chk("sat_cnt", int'(match_count), CMAX);
    chk("sat_out", int'(out), 1);
    step(0, 1, 4'h1, 1, 0, 0, 0);
    chk("reload_cnt", int'(match_count), 0);

    // sticky irq behaviour
    step(0, 0, 0, 0, 0, 0, 1);
    chk("irq_clr", int'(irq), 0);
    step(0, 0, 0, 0, 1, 1, 0);
    chk("irq_set", int'(irq), int'(IRQ_ON));
    repeat (3) step(0, 0, 0, 0, 0, 0, 0);
    chk("irq_hold", int'(irq), int'(IRQ_ON));
    step(0, 0, 0, 0, 0, 0, 1);
    chk("irq_clr2", int'(irq), 0);
    step(0, 0, 0, 0, 1, 1, 1);
    chk("irq_set_wins", int'(irq), int'(IRQ_ON));
    step(0, 1, 4'h6, 3, 0, 0, 0);
    chk("irq_load_keep", int'(irq), int'(IRQ_ON));

    // random traffic against the model
    step(1, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 4000; n++) begin
      bit rst, cfg, val, b, clr;
      bit [3:0] pat;
      int len;
      rst = ($urandom_range(0, 199) == 0);
      cfg = ($urandom_range(0, 19) == 0);
      pat = 4'($urandom);
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7)
                                        : $urandom_range(1, 4);
      val = ($urandom_range(0, 9) < 7);
      b   = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 15) == 0);
      step(rst, cfg, pat, len, val, b, clr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
